// File: rtl/snn_mem_pkg.sv
// Shared types for the SNN memory access scheduler: memory op codes,
// scheduler FSM states and a read/write classifier.
package snn_mem_pkg;

  typedef enum logic [2:0] {
    RD_VPOT  = 3'd0,
    RD_IFMAP = 3'd1,
    RD_FILT  = 3'd2,
    WR_VPOT  = 3'd3,
    WR_SPIKE = 3'd4
  } mem_op_e;

  typedef enum logic [2:0] {
    ARB,
    ISSUE,
    WAIT_RSP,
    ADV_T,
    DONE
  } sched_state_e;

  // Reads return data through WAIT_RSP; everything else completes at the command handshake.
  function automatic logic is_read(input logic [2:0] op);
    return (op == RD_VPOT) || (op == RD_IFMAP) || (op == RD_FILT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found searching
// upward (with wrap) from ptr. Returns both a one-hot grant and its index.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Rotating priority search starting at ptr.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IDX_W'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// Shares the single-ported SNN memory among NUM_REQ requesters. One transaction
// is in flight at a time; read data is routed back to its owner. Timestep
// advance requests are merged, wait for in-flight traffic, then send T to memory.
module mem_access_scheduler
  import snn_mem_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TIMESTEPS = 10,
  parameter int unsigned OF_ROWS   = 3,
  parameter int unsigned OF_COLS   = 3,
  parameter int unsigned IF_ROWS   = 5,
  parameter int unsigned IF_COLS   = 5,
  parameter int unsigned F_ROWS    = 3,
  parameter int unsigned F_COLS    = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned T_W       = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*3-1:0]       req_op,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       mem_cmd_valid,
  input  logic                       mem_cmd_ready,
  output logic [2:0]                 mem_cmd_op,
  output logic [COORD_W-1:0]         mem_cmd_x,
  output logic [COORD_W-1:0]         mem_cmd_y,
  output logic [DATA_W-1:0]          mem_cmd_wdata,
  input  logic                       mem_rsp_valid,
  input  logic [DATA_W-1:0]          mem_rsp_data,
  input  logic                       ts_advance_req,
  output logic                       mem_t_valid,
  input  logic                       mem_t_ready,
  output logic [T_W-1:0]             mem_t_value,
  output logic [T_W-1:0]             timestep,
  output logic                       done,
  output logic                       err_illegal
);

  localparam int unsigned        IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [T_W-1:0]     LAST_T   = T_W'(TIMESTEPS);

  // Per-requester views of the flattened request buses.
  logic [2:0]         op_arr [NUM_REQ];
  logic [COORD_W-1:0] x_arr  [NUM_REQ];
  logic [COORD_W-1:0] y_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wd_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[g*3 +: 3];
    assign x_arr[g]  = req_x[g*COORD_W +: COORD_W];
    assign y_arr[g]  = req_y[g*COORD_W +: COORD_W];
    assign wd_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  sched_state_e       state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  logic               adv_pending_q, adv_pending_d;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               cmd_valid_q;
  logic [2:0]         cmd_op_q;
  logic [COORD_W-1:0] cmd_x_q, cmd_y_q;
  logic [DATA_W-1:0]  cmd_wdata_q;
  logic               t_valid_q;
  logic [T_W-1:0]     t_value_q;
  logic [T_W-1:0]     timestep_q;
  logic               done_q;
  logic               err_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   ptr_next;
  logic [2:0]         sel_op;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_legal;
  logic [T_W-1:0]     ts_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Each op addresses a different array, so each has its own x/y bounds.
  function automatic logic op_in_bounds(input logic [2:0] op,
                                        input logic [COORD_W-1:0] x,
                                        input logic [COORD_W-1:0] y);
    logic ok;
    ok = 1'b0;
    case (op)
      RD_VPOT, WR_VPOT, WR_SPIKE: ok = (32'(x) < OF_ROWS) && (32'(y) < OF_COLS);
      RD_IFMAP:                   ok = (32'(x) < IF_ROWS) && (32'(y) < IF_COLS);
      RD_FILT:                    ok = (32'(x) < F_ROWS)  && (32'(y) < F_COLS);
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign sel_op    = op_arr[arb_idx];
  assign sel_x     = x_arr[arb_idx];
  assign sel_y     = y_arr[arb_idx];
  assign sel_wdata = wd_arr[arb_idx];
  assign sel_legal = op_in_bounds(sel_op, sel_x, sel_y);
  assign ptr_next  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
  assign ts_next   = timestep_q + T_W'(1);

  // Advance requests are merged into one pending flag, cleared by the T handshake.
  always_comb begin
    adv_pending_d = adv_pending_q;
    if (ts_advance_req && (state_q != DONE)) adv_pending_d = 1'b1;
    if ((state_q == ADV_T) && t_valid_q && mem_t_ready) adv_pending_d = 1'b0;
  end

  // Scheduler FSM; all outputs come straight from these registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      adv_pending_q <= 1'b0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= '0;
      cmd_x_q       <= '0;
      cmd_y_q       <= '0;
      cmd_wdata_q   <= '0;
      t_valid_q     <= 1'b0;
      t_value_q     <= '0;
      timestep_q    <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values.
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      adv_pending_q <= adv_pending_d;
      case (state_q)
        ARB: begin
          if (adv_pending_q) begin
            state_q     <= ADV_T;
            t_valid_q   <= 1'b1;
            t_value_q   <= ts_next;
            cmd_op_q    <= '0;
            cmd_x_q     <= '0;
            cmd_y_q     <= '0;
            cmd_wdata_q <= '0;
          end else if (|req_valid) begin
            req_ready_q <= arb_gnt;
            rr_ptr_q    <= ptr_next;
            if (sel_legal) begin
              owner_q     <= arb_idx;
              cmd_op_q    <= sel_op;
              cmd_x_q     <= sel_x;
              cmd_y_q     <= sel_y;
              cmd_wdata_q <= sel_wdata;
              state_q     <= ISSUE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (!cmd_valid_q) begin
            cmd_valid_q <= 1'b1;
          end else if (mem_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= is_read(cmd_op_q) ? WAIT_RSP : ARB;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid) begin
            rsp_data_q  <= mem_rsp_data;
            rsp_valid_q <= ONE_HOT0 << owner_q;
            state_q     <= ARB;
          end
        end
        ADV_T: begin
          if (mem_t_ready) begin
            t_valid_q  <= 1'b0;
            timestep_q <= ts_next;
            if (ts_next == LAST_T) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= ARB;
            end
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= ARB;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_cmd_op    = cmd_op_q;
  assign mem_cmd_x     = cmd_x_q;
  assign mem_cmd_y     = cmd_y_q;
  assign mem_cmd_wdata = cmd_wdata_q;
  assign mem_t_valid   = t_valid_q;
  assign mem_t_value   = t_value_q;
  assign timestep      = timestep_q;
  assign done          = done_q;
  assign err_illegal   = err_q;

endmodule
